// File: rtl/compare_scheduler.sv
// Round-robin scheduler sharing one unsigned magnitude comparator between NREQ requesters.
// Each accepted request passes through COMPARE and RESPOND before the next grant.
module compare_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_gt,
  output logic                    rsp_lt,
  output logic                    rsp_eq,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             gt_q, lt_q, eq_q;

  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant_oh;
  logic [WIDTH-1:0] a_sel, b_sel;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req_valid[idx[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[IDW-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign grant_oh[gi] = grant_any && (grant_idx == IDW'(gi));
    end
  endgenerate

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        a_sel = req_a[k*WIDTH +: WIDTH];
        b_sel = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = COMPARE;
      COMPARE: state_d = RESPOND;
      RESPOND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset_n so no strobe escapes while reset is held.
  assign req_ready = (reset_n && state_q == IDLE) ? grant_oh : '0;
  assign rsp_valid = (state_q == RESPOND);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_gt    = gt_q;
  assign rsp_lt    = lt_q;
  assign rsp_eq    = eq_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_any) begin
        id_q <= grant_idx;
        a_q  <= a_sel;
        b_q  <= b_sel;
      end
      if (state_q == COMPARE) begin
        gt_q <= (a_q > b_q);
        lt_q <= (a_q < b_q);
        eq_q <= (a_q == b_q);
      end
      if (state_q == RESPOND && rsp_ready) begin
        rr_ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_compare_scheduler.sv
// Bench for compare_scheduler: directed vector table, hand-written corner sequences,
// and randomized transactions checked against a round-robin reference model.
module tb_compare_scheduler;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_gt, rsp_lt, rsp_eq;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int mdl_rr = 0;

  compare_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: scan requesters from the pointer with wrap; -1 when none valid.
  function automatic int mdl_winner(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [2:0] mdl_flags(input int a, input int b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  // Entered in IDLE just after a rising edge; leaves just after a rising edge in IDLE.
  task automatic run_txn(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] av,
                         input logic [NREQ*WIDTH-1:0] bv, input int exp_id,
                         input logic [2:0] exp_f, input int stall, input bit scramble,
                         input string tag);
    logic [NREQ-1:0] exp_ready;
    exp_ready = (exp_id < 0) ? '0 : (NREQ'(1) << exp_id);
    req_valid = v;
    req_a     = av;
    req_b     = bv;
    rsp_ready = (stall == 0);
    #1;
    chk({tag, " req_ready"}, req_ready, exp_ready);
    if (exp_id < 0) begin
      @(posedge clock); #1;
      chk({tag, " idle busy"}, busy, 0);
      $display("txn %s: no request, stays idle", tag);
      return;
    end
    @(posedge clock); #1;
    chk({tag, " compare busy"}, busy, 1);
    chk({tag, " compare rsp_valid"}, rsp_valid, 0);
    chk({tag, " compare req_ready"}, req_ready, 0);
    if (scramble) begin
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
    end
    @(posedge clock); #1;
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " rsp_id"}, rsp_id, exp_id);
    chk({tag, " flags"}, {rsp_gt, rsp_lt, rsp_eq}, exp_f);
    for (int s = 1; s < stall; s++) begin
      if (scramble) req_a = {$urandom, $urandom};
      @(posedge clock); #1;
      chk({tag, " hold rsp_valid"}, rsp_valid, 1);
      chk({tag, " hold rsp_id"}, rsp_id, exp_id);
      chk({tag, " hold flags"}, {rsp_gt, rsp_lt, rsp_eq}, exp_f);
      chk({tag, " hold req_ready"}, req_ready, 0);
    end
    if (stall > 0) begin
      rsp_ready = 1'b1;
      @(posedge clock); #1;
    end else begin
      @(posedge clock); #1;
    end
    chk({tag, " done rsp_valid"}, rsp_valid, 0);
    chk({tag, " done busy"}, busy, 0);
    mdl_rr = (exp_id + 1) % NREQ;
    $display("txn %s: v=%b id=%0d flags=%b stall=%0d", tag, v, exp_id, exp_f, stall);
  endtask

  typedef struct {
    logic [NREQ-1:0]  v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               id;
    logic [2:0]       f;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [NREQ*WIDTH-1:0] av, bv;
    logic [NREQ-1:0]       v;
    int                    w;

    tbl = '{
      '{4'b1111, 4'h3, 4'h5, 0, 3'b010},
      '{4'b1111, 4'h9, 4'h2, 1, 3'b100},
      '{4'b1111, 4'h6, 4'h6, 2, 3'b001},
      '{4'b1111, 4'h0, 4'h1, 3, 3'b010},
      '{4'b1111, 4'hF, 4'hE, 0, 3'b100},
      '{4'b1111, 4'h4, 4'h4, 1, 3'b001},
      '{4'b1111, 4'h1, 4'h8, 2, 3'b010},
      '{4'b1111, 4'hC, 4'hB, 3, 3'b100},
      '{4'b0001, 4'hA, 4'h3, 0, 3'b100},
      '{4'b0001, 4'h7, 4'h7, 0, 3'b001},
      '{4'b0001, 4'h0, 4'hF, 0, 3'b010},
      '{4'b0001, 4'hF, 4'h0, 0, 3'b100},
      '{4'b0100, 4'h5, 4'h5, 2, 3'b001},
      '{4'b0000, 4'h0, 4'h0, -1, 3'b000},
      '{4'b1111, 4'h8, 4'h8, 3, 3'b001}
    };

    reset_n   = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    chk("reset req_ready", req_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_id", rsp_id, 0);
    chk("reset flags", {rsp_gt, rsp_lt, rsp_eq}, 0);
    @(negedge clock);
    req_valid = '0;
    reset_n   = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 15; i++) begin
      av = {NREQ{~tbl[i].a}};
      bv = {NREQ{~tbl[i].b}};
      if (tbl[i].id >= 0) begin
        av[tbl[i].id*WIDTH +: WIDTH] = tbl[i].a;
        bv[tbl[i].id*WIDTH +: WIDTH] = tbl[i].b;
      end
      run_txn(tbl[i].v, av, bv, tbl[i].id, tbl[i].f, 0, 0, $sformatf("vec%0d", i));
    end

    // Backpressure with operands changing while the result is held.
    av = 16'h1111 * 4'h2;
    bv = 16'h1111 * 4'h9;
    av[1*WIDTH +: WIDTH] = 4'hD;
    bv[1*WIDTH +: WIDTH] = 4'h6;
    run_txn(4'b0010, av, bv, 1, 3'b100, 5, 1, "backpressure");

    // Reset during COMPARE drops the transaction and restarts the pointer at 0.
    req_valid = 4'b1111;
    req_a     = 16'h1234;
    req_b     = 16'h4321;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    chk("midreset compare busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset rsp_valid", rsp_valid, 0);
    chk("midreset req_ready", req_ready, 0);
    @(posedge clock); #1;
    chk("midreset held rsp_valid", rsp_valid, 0);
    @(negedge clock);
    reset_n = 1'b1;
    mdl_rr  = 0;
    $display("txn midreset: in-flight comparison discarded");
    run_txn(4'b1111, 16'h5555, 16'h5555, 0, 3'b001, 0, 0, "post_reset");

    for (int t = 0; t < 200; t++) begin
      v = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        av[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        bv[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? av[i*WIDTH +: WIDTH]
                                                           : WIDTH'($urandom);
      end
      w = mdl_winner(v, mdl_rr);
      run_txn(v, av, bv, w,
              (w < 0) ? 3'b000 : mdl_flags(int'(av[w*WIDTH +: WIDTH]), int'(bv[w*WIDTH +: WIDTH])),
              $urandom_range(0, 3), 1, $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
